// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: scans two WIDTH-bit operands one 2-bit digit
// per clock, MSB digit first, stopping at the first unequal digit.

module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       g,
    output logic       e,
    output logic       l
);
    assign g = (a > b);
    assign e = (a == b);
    assign l = (a < b);
endmodule

module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);
    localparam int SLICES = WIDTH / 2;
    localparam int CW     = $clog2(SLICES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_sa, w_sa_next;
    logic [WIDTH-1:0] r_sb, w_sb_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_done, w_done_next;
    logic             r_g, w_g_next;
    logic             r_e, w_e_next;
    logic             r_l, w_l_next;

    logic             w_sg, w_se, w_sl;

    // The slice always looks at the top digit; equal digits are shifted out.
    comparator_2bit u_slice (
        .a (r_sa[WIDTH-1 -: 2]),
        .b (r_sb[WIDTH-1 -: 2]),
        .g (w_sg),
        .e (w_se),
        .l (w_sl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_l     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sa    <= w_sa_next;
            r_sb    <= w_sb_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            r_g     <= w_g_next;
            r_e     <= w_e_next;
            r_l     <= w_l_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sa_next    = r_sa;
        w_sb_next    = r_sb;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_g_next     = r_g;
        w_e_next     = r_e;
        w_l_next     = r_l;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sa_next    = a;
                    w_sb_next    = b;
                    w_cnt_next   = CW'(SLICES);
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!w_se) begin
                    w_g_next     = w_sg;
                    w_e_next     = 1'b0;
                    w_l_next     = w_sl;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_g_next     = 1'b0;
                    w_e_next     = 1'b1;
                    w_l_next     = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_sa_next  = r_sa << 2;
                    w_sb_next  = r_sb << 2;
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign g    = r_g;
    assign e    = r_e;
    assign l    = r_l;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed, table-driven and random checks of serial_magnitude_comparator at WIDTH=8,
// plus an exhaustive sweep of a WIDTH=2 instance.

module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [7:0] a, b;
    logic [1:0] a2, b2;
    logic       busy, done, g, e, l;
    logic       busy2, done2, g2, e2, l2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .g(g), .e(e), .l(l)
    );

    serial_magnitude_comparator #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .g(g2), .e(e2), .l(l2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] gel;
        int         k;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int ref_k(input logic [7:0] x, input logic [7:0] y);
        for (int d = 3; d >= 0; d--)
            if (x[2*d +: 2] != y[2*d +: 2]) return 4 - d;
        return 4;
    endfunction

    function automatic logic [2:0] ref_gel(input logic [7:0] x, input logic [7:0] y);
        return {x > y, x == y, x < y};
    endfunction

    // Launches one compare and waits for done; returns at #1 after the done-raising edge.
    task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [2:0] exp_gel, input int exp_k,
                           input string nm, input bit quiet);
        int k, bc;
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tb_v;
        @(posedge clk); #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        bc = busy ? 1 : 0;
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (busy && !done) bc++;
        end
        chk({nm, " latency"}, k, exp_k);
        chk({nm, " gel"}, {g, e, l}, exp_gel);
        if (!quiet) begin
            chk({nm, " busy cycles"}, bc, exp_k);
            $display("[TB] %s a=%02h b=%02h k=%0d gel=%03b", nm, ta, tb_v, k, {g, e, l});
        end
    endtask

    initial begin
        int k, hits;
        logic [7:0] ra, rb;

        vecs[0] = '{8'hA5, 8'hA5, 3'b010, 4};
        vecs[1] = '{8'h80, 8'h7F, 3'b100, 1};
        vecs[2] = '{8'h34, 8'h35, 3'b001, 4};
        vecs[3] = '{8'h10, 8'h20, 3'b001, 2};
        vecs[4] = '{8'hFF, 8'h00, 3'b100, 1};
        vecs[5] = '{8'h00, 8'h00, 3'b010, 4};
        vecs[6] = '{8'hC3, 8'hC2, 3'b100, 4};
        vecs[7] = '{8'h0F, 8'h0C, 3'b100, 4};
        vecs[8] = '{8'h12, 8'h13, 3'b001, 4};
        vecs[9] = '{8'h5A, 8'h56, 3'b100, 3};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset gel", {g, e, l}, 3'b000);
        chk("reset busy2", busy2, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].gel, vecs[i].k, $sformatf("vec%0d", i), 1'b0);

        // start while in RUN must be ignored
        @(posedge clk); #1;
        start = 1'b1; a = 8'h34; b = 8'h35;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        k = 2;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ignore-start latency", k, 4);
        chk("ignore-start gel", {g, e, l}, 3'b001);
        @(posedge clk); #1;
        chk("ignore-start no restart", busy, 0);
        $display("[TB] ignore-start k=%0d gel=%03b", k, {g, e, l});

        // back-to-back: start issued in the done cycle
        run_cmp(8'hA5, 8'hA5, 3'b010, 4, "b2b first", 1'b0);
        start = 1'b1; a = 8'h10; b = 8'h20;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b accepted busy", busy, 1);
        chk("b2b hold gel", {g, e, l}, 3'b010);
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (!done) chk("b2b hold gel run", {g, e, l}, 3'b010);
        end
        chk("b2b latency", k, 2);
        chk("b2b gel", {g, e, l}, 3'b001);
        $display("[TB] b2b second k=%0d gel=%03b", k, {g, e, l});

        // asynchronous reset mid-compare
        @(posedge clk); #1;
        start = 1'b1; a = 8'h12; b = 8'h12;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort busy before", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort gel", {g, e, l}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) hits++;
        end
        chk("abort no done", hits, 0);
        $display("[TB] abort reset cleared gel=%03b", {g, e, l});
        run_cmp(8'h12, 8'h12, 3'b010, 4, "after abort", 1'b0);

        // random pairs against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom);
            run_cmp(ra, rb, ref_gel(ra, rb), ref_k(ra, rb), $sformatf("rand%0d", i), 1'b1);
        end
        $display("[TB] random sweep of 1000 pairs complete");

        // exhaustive WIDTH=2
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                @(posedge clk); #1;
                start2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
                @(posedge clk); #1;
                start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
                k = 0;
                while (!done2 && k < 10) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk($sformatf("w2 %0d/%0d latency", x, y), k, 1);
                chk($sformatf("w2 %0d/%0d gel", x, y), {g2, e2, l2},
                    {x > y, x == y, x < y});
                $display("[TB] w2 a=%0d b=%0d k=%0d gel=%03b", x, y, k, {g2, e2, l2});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
